// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, delayed-redirect handling with a
// one-entry pending slot, fetch fault detection, and the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_ce,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus8,
    output logic [31:0] if_id_inst,
    output logic        if_id_fault
);

    localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

    logic [31:0] r_pc;
    logic        r_ce;
    logic        r_pend;
    logic [31:0] r_pend_pc;

    logic        r_if_id_valid;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_pc_plus8;
    logic [31:0] r_if_id_inst;
    logic        r_if_id_fault;

    logic        w_fault;
    logic [31:0] w_next_pc;

    assign w_fault   = (r_pc[1:0] != 2'b00) || ({1'b0, r_pc} >= PC_LIMIT);
    assign inst_addr = r_pc;
    assign inst_ce   = r_ce & ~w_fault;

    // Until the fetch enable comes up the PC is pinned, so the first fetch is RESET_PC.
    always_comb begin
        // NOTE: default first so every path assigns w_next_pc and no latch is inferred.
        w_next_pc = r_pc;
        if (!r_ce)
            w_next_pc = r_pc;
        else if (flush && redirect_valid)
            w_next_pc = redirect_pc;
        else if (stall)
            w_next_pc = r_pc;
        else if (r_pend)
            w_next_pc = r_pend_pc;
        else if (redirect_valid)
            w_next_pc = redirect_pc;
        else
            w_next_pc = r_pc + 32'd4;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_ce      <= 1'b0;
            r_pend    <= 1'b0;
            r_pend_pc <= 32'h0;
        end else begin
            r_pc <= w_next_pc;
            r_ce <= 1'b1;
            if (flush) begin
                r_pend <= 1'b0;
            end else if (stall) begin
                // A later redirect during the same stall overwrites the stored target.
                if (redirect_valid) begin
                    r_pend    <= 1'b1;
                    r_pend_pc <= redirect_pc;
                end
            end else begin
                r_pend <= 1'b0;
            end
        end
    end

    // The instruction in IF is never squashed by a redirect: it is the delay slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_id_valid    <= 1'b0;
            r_if_id_pc       <= 32'h0;
            r_if_id_pc_plus8 <= 32'h0;
            r_if_id_inst     <= 32'h0;
            r_if_id_fault    <= 1'b0;
        end else if (flush) begin
            r_if_id_valid <= 1'b0;
            r_if_id_inst  <= 32'h0;
            r_if_id_fault <= 1'b0;
        end else if (!stall) begin
            r_if_id_valid    <= r_ce;
            r_if_id_pc       <= r_pc;
            r_if_id_pc_plus8 <= r_pc + 32'd8;
            r_if_id_inst     <= w_fault ? 32'h0 : inst_data;
            r_if_id_fault    <= w_fault;
        end
    end

    assign if_id_valid    = r_if_id_valid;
    assign if_id_pc       = r_if_id_pc;
    assign if_id_pc_plus8 = r_if_id_pc_plus8;
    assign if_id_inst     = r_if_id_inst;
    assign if_id_fault    = r_if_id_fault;

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage: each vector gives the inputs for
// one edge and the outputs expected just after it; reset corners are hand-written.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ce;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus8;
    logic [31:0] if_id_inst;
    logic        if_id_fault;

    int n_cmp = 0;
    int n_bad = 0;

    if_stage #(.RESET_PC(32'h0), .MEM_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_ce(inst_ce), .inst_addr(inst_addr), .inst_data(inst_data),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_pc_plus8(if_id_pc_plus8), .if_id_inst(if_id_inst),
        .if_id_fault(if_id_fault)
    );

    // Memory model: the word at address a is {a[15:0], 16'hF025}, so addr 0 holds 32'h0000F025.
    assign inst_data = {inst_addr[15:0], 16'hF025};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic        e_ce;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_pc8;
        logic [31:0] e_inst;
        logic        e_fault;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    function automatic vec_t mk(logic s, logic f, logic rv, logic [31:0] rpc,
                                logic [31:0] a, logic ce, logic v, logic [31:0] pc,
                                logic [31:0] pc8, logic [31:0] inst, logic flt);
        vec_t t;
        t.stall = s;  t.flush = f;  t.rv = rv;  t.rpc = rpc;
        t.e_addr = a; t.e_ce = ce;  t.e_valid = v; t.e_pc = pc;
        t.e_pc8 = pc8; t.e_inst = inst; t.e_fault = flt;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] a, input logic ce,
                             input logic v, input logic [31:0] pc, input logic [31:0] pc8,
                             input logic [31:0] inst, input logic flt);
        check({tag, " inst_addr"}, inst_addr, a);
        check({tag, " inst_ce"}, {31'h0, inst_ce}, {31'h0, ce});
        check({tag, " if_id_valid"}, {31'h0, if_id_valid}, {31'h0, v});
        check({tag, " if_id_pc"}, if_id_pc, pc);
        check({tag, " if_id_pc_plus8"}, if_id_pc_plus8, pc8);
        check({tag, " if_id_inst"}, if_id_inst, inst);
        check({tag, " if_id_fault"}, {31'h0, if_id_fault}, {31'h0, flt});
    endtask

    task automatic drive(input logic s, input logic f, input logic rv, input logic [31:0] rpc);
        stall = s;
        flush = f;
        redirect_valid = rv;
        redirect_pc = rpc;
    endtask

    initial begin
        //             stall flush rv  rpc          addr         ce  v   if_pc        pc+8         inst          fault
        vecs[0]  = mk(0, 0, 0, 32'h0,   32'h0,    1, 0, 32'h0,   32'h8,    32'h0000F025, 0);
        vecs[1]  = mk(0, 0, 0, 32'h0,   32'h4,    1, 1, 32'h0,   32'h8,    32'h0000F025, 0);
        vecs[2]  = mk(0, 0, 0, 32'h0,   32'h8,    1, 1, 32'h4,   32'hC,    32'h0004F025, 0);
        vecs[3]  = mk(0, 0, 0, 32'h0,   32'hC,    1, 1, 32'h8,   32'h10,   32'h0008F025, 0);
        vecs[4]  = mk(0, 0, 0, 32'h0,   32'h10,   1, 1, 32'hC,   32'h14,   32'h000CF025, 0);
        // Redirect to 0x20 while PC=0x10: 0x10 still enters IF/ID as the delay slot.
        vecs[5]  = mk(0, 0, 1, 32'h20,  32'h20,   1, 1, 32'h10,  32'h18,   32'h0010F025, 0);
        vecs[6]  = mk(0, 0, 0, 32'h0,   32'h24,   1, 1, 32'h20,  32'h28,   32'h0020F025, 0);
        // Three-cycle stall with redirect 0x150 in the first stalled cycle.
        vecs[7]  = mk(1, 0, 1, 32'h150, 32'h24,   1, 1, 32'h20,  32'h28,   32'h0020F025, 0);
        vecs[8]  = mk(1, 0, 0, 32'h0,   32'h24,   1, 1, 32'h20,  32'h28,   32'h0020F025, 0);
        vecs[9]  = mk(1, 0, 0, 32'h0,   32'h24,   1, 1, 32'h20,  32'h28,   32'h0020F025, 0);
        vecs[10] = mk(0, 0, 0, 32'h0,   32'h150,  1, 1, 32'h24,  32'h2C,   32'h0024F025, 0);
        vecs[11] = mk(0, 0, 0, 32'h0,   32'h154,  1, 1, 32'h150, 32'h158,  32'h0150F025, 0);
        // Pending 0x200, then flush+redirect 0x180 during stall: pending must be dropped.
        vecs[12] = mk(1, 0, 1, 32'h200, 32'h154,  1, 1, 32'h150, 32'h158,  32'h0150F025, 0);
        vecs[13] = mk(1, 1, 1, 32'h180, 32'h180,  1, 0, 32'h150, 32'h158,  32'h0,        0);
        vecs[14] = mk(0, 0, 0, 32'h0,   32'h184,  1, 1, 32'h180, 32'h188,  32'h0180F025, 0);
        // Second redirect during a stall overwrites the pending target.
        vecs[15] = mk(1, 0, 1, 32'h300, 32'h184,  1, 1, 32'h180, 32'h188,  32'h0180F025, 0);
        vecs[16] = mk(1, 0, 1, 32'h340, 32'h184,  1, 1, 32'h180, 32'h188,  32'h0180F025, 0);
        vecs[17] = mk(0, 0, 0, 32'h0,   32'h340,  1, 1, 32'h184, 32'h18C,  32'h0184F025, 0);
        // Misaligned and out-of-range fetches, then the last valid word.
        vecs[18] = mk(0, 0, 1, 32'h22,  32'h22,   0, 1, 32'h340, 32'h348,  32'h0340F025, 0);
        vecs[19] = mk(0, 0, 0, 32'h0,   32'h26,   0, 1, 32'h22,  32'h2A,   32'h0,        1);
        vecs[20] = mk(0, 0, 1, 32'h1000, 32'h1000, 0, 1, 32'h26,  32'h2E,   32'h0,        1);
        vecs[21] = mk(0, 0, 0, 32'h0,   32'h1004, 0, 1, 32'h1000, 32'h1008, 32'h0,        1);
        vecs[22] = mk(0, 0, 1, 32'hFFC, 32'hFFC,  1, 1, 32'h1004, 32'h100C, 32'h0,        1);
        vecs[23] = mk(0, 0, 0, 32'h0,   32'h1000, 0, 1, 32'hFFC, 32'h1004, 32'h0FFCF025, 0);

        rst = 1'b1;
        drive(0, 0, 0, 32'h0);
        #12;
        check_all("reset", 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all("release", 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].rv, vecs[i].rpc);
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_ce, vecs[i].e_valid,
                      vecs[i].e_pc, vecs[i].e_pc8, vecs[i].e_inst, vecs[i].e_fault);
        end

        // Reset asserted mid-stall with a pending redirect: everything clears at once.
        drive(1, 0, 1, 32'h500);
        @(posedge clk);
        #1;
        drive(1, 0, 0, 32'h0);
        rst = 1'b1;
        #1;
        check_all("async_rst", 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        check_all("post_rst0", 32'h0, 1, 0, 32'h0, 32'h8, 32'h0000F025, 0);
        @(posedge clk);
        #1;
        check_all("post_rst1", 32'h4, 1, 1, 32'h0, 32'h8, 32'h0000F025, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
